// File: rtl/matrix_result_streamer.sv
// Captures one SIZE x SIZE product from the systolic multiplier and streams it
// out element by element in row-major order over a valid/ready interface.
module matrix_result_streamer #(
  parameter int WIDTH = 16,
  parameter int SIZE  = 32,
  parameter int IW    = $clog2(SIZE)
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic                                 start_i,
  output logic                                 mul_valid_o,
  input  logic                                 mul_ready_i,
  input  logic [SIZE-1:0][SIZE-1:0][WIDTH-1:0] mul_result_i,
  output logic [WIDTH-1:0]                     m_data_o,
  output logic [IW-1:0]                        m_row_o,
  output logic [IW-1:0]                        m_col_o,
  output logic                                 m_valid_o,
  output logic                                 m_last_o,
  input  logic                                 m_ready_i,
  output logic                                 busy_o,
  output logic [15:0]                          jobs_done_o
);

  // state | meaning
  // IDLE  | no job; waits for start_i
  // WAIT  | requesting a product from the multiplier
  // DRAIN | streaming the captured buffer, one element per handshake
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DRAIN} state_t;

  localparam logic [IW-1:0] LAST_IDX = IW'(SIZE - 1);

  state_t                               state_q, state_d;
  logic [IW-1:0]                        row_q, row_d;
  logic [IW-1:0]                        col_q, col_d;
  logic [15:0]                          jobs_q, jobs_d;
  logic [SIZE-1:0][SIZE-1:0][WIDTH-1:0] res_buf_q, res_buf_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_IDLE;
      row_q     <= '0;
      col_q     <= '0;
      jobs_q    <= '0;
      res_buf_q <= '0;
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      col_q     <= col_d;
      jobs_q    <= jobs_d;
      res_buf_q <= res_buf_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    col_d       = col_q;
    jobs_d      = jobs_q;
    res_buf_d   = res_buf_q;
    mul_valid_o = 1'b0;
    m_valid_o   = 1'b0;
    m_last_o    = 1'b0;
    m_data_o    = '0;
    m_row_o     = '0;
    m_col_o     = '0;
    busy_o      = (state_q != S_IDLE);

    unique case (state_q)
      S_IDLE: begin
        if (start_i) state_d = S_WAIT;
      end
      S_WAIT: begin
        mul_valid_o = 1'b1;
        if (mul_ready_i) begin
          res_buf_d = mul_result_i;
          row_d     = '0;
          col_d     = '0;
          state_d   = S_DRAIN;
        end
      end
      S_DRAIN: begin
        m_valid_o = 1'b1;
        m_data_o  = res_buf_q[row_q][col_q];
        m_row_o   = row_q;
        m_col_o   = col_q;
        m_last_o  = (row_q == LAST_IDX) && (col_q == LAST_IDX);
        // Indices only move on a handshake, which keeps the output stable under backpressure.
        if (m_ready_i) begin
          if (col_q != LAST_IDX) begin
            col_d = col_q + 1'b1;
          end else begin
            col_d = '0;
            if (row_q == LAST_IDX) begin
              row_d   = '0;
              jobs_d  = jobs_q + 16'd1;
              state_d = S_IDLE;
            end else begin
              row_d = row_q + 1'b1;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign jobs_done_o = jobs_q;

endmodule

// File: tb/tb_matrix_result_streamer.sv
// Self-checking bench for matrix_result_streamer: vector table for a basic job,
// queue-based reference model for randomized jobs, and a SIZE=32 drain.
module tb_matrix_result_streamer;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic                     reset;
  logic                     start_i, mul_ready_i, m_ready_i;
  logic [3:0][3:0][15:0]    mul_result_i;
  logic                     mul_valid_o, m_valid_o, m_last_o, busy_o;
  logic [15:0]              m_data_o, jobs_done_o;
  logic [1:0]               m_row_o, m_col_o;

  matrix_result_streamer #(.WIDTH(16), .SIZE(4)) dut (
    .clock(clock), .reset(reset), .start_i(start_i), .mul_valid_o(mul_valid_o),
    .mul_ready_i(mul_ready_i), .mul_result_i(mul_result_i), .m_data_o(m_data_o),
    .m_row_o(m_row_o), .m_col_o(m_col_o), .m_valid_o(m_valid_o), .m_last_o(m_last_o),
    .m_ready_i(m_ready_i), .busy_o(busy_o), .jobs_done_o(jobs_done_o)
  );

  logic                     start32, mul_ready32, m_ready32;
  logic [31:0][31:0][15:0]  mul_result32;
  logic                     mul_valid32, m_valid32, m_last32, busy32;
  logic [15:0]              m_data32, jobs32;
  logic [4:0]               m_row32, m_col32;

  matrix_result_streamer #(.WIDTH(16), .SIZE(32)) dut32 (
    .clock(clock), .reset(reset), .start_i(start32), .mul_valid_o(mul_valid32),
    .mul_ready_i(mul_ready32), .mul_result_i(mul_result32), .m_data_o(m_data32),
    .m_row_o(m_row32), .m_col_o(m_col32), .m_valid_o(m_valid32), .m_last_o(m_last32),
    .m_ready_i(m_ready32), .busy_o(busy32), .jobs_done_o(jobs32)
  );

  int pass_cnt = 0;
  int total_cnt = 0;
  int jobs_exp = 0;

  typedef struct {
    logic        start, mul_ready, m_ready;
    logic        e_mul_valid, e_m_valid, e_busy, e_last;
    logic [15:0] e_data;
    logic [1:0]  e_row, e_col;
    logic [15:0] e_jobs;
  } vec_t;
  vec_t vecs[$];

  typedef struct {
    logic [15:0] d;
    int          r;
    int          c;
  } elem_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_outputs(input string tag, input int jobs);
    chk({tag, "_mul_valid"}, mul_valid_o, 0);
    chk({tag, "_m_valid"}, m_valid_o, 0);
    chk({tag, "_busy"}, busy_o, 0);
    chk({tag, "_last"}, m_last_o, 0);
    chk({tag, "_data"}, m_data_o, 0);
    chk({tag, "_row"}, m_row_o, 0);
    chk({tag, "_col"}, m_col_o, 0);
    chk({tag, "_jobs"}, jobs_done_o, 32'(jobs));
  endtask

  task automatic load_ramp();
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        mul_result_i[i][j] = 16'(16 * i + j);
  endtask

  // bp_pct < 0 selects the fixed ready pattern 1,0,0,1,0,0,...
  task automatic run_job(input string tag, input int bp_pct, input bit overwrite,
                         input logic [3:0][3:0][15:0] mat);
    elem_t q[$];
    int    cyc;
    int    hs;
    bit    done;
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    chk({tag, "_req_mul_valid"}, mul_valid_o, 1);
    chk({tag, "_req_busy"}, busy_o, 1);
    repeat ($urandom_range(3)) begin
      step();
      chk({tag, "_wait_mul_valid"}, mul_valid_o, 1);
      chk({tag, "_wait_m_valid"}, m_valid_o, 0);
    end
    mul_result_i = mat;
    mul_ready_i  = 1'b1;
    step();
    mul_ready_i = 1'b0;
    chk({tag, "_cap_mul_valid"}, mul_valid_o, 0);
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        q.push_back('{d: mat[i][j], r: i, c: j});
    if (overwrite) mul_result_i = {16{16'hFFFF}};
    cyc  = 0;
    hs   = 0;
    done = 1'b0;
    while (!done && cyc < 200) begin
      if (q.size() > 0) begin
        chk({tag, "_m_valid"}, m_valid_o, 1);
        chk({tag, "_data"}, m_data_o, q[0].d);
        chk({tag, "_row"}, m_row_o, q[0].r);
        chk({tag, "_col"}, m_col_o, q[0].c);
        chk({tag, "_last"}, m_last_o, q.size() == 1);
        chk({tag, "_busy"}, busy_o, 1);
        m_ready_i   = (bp_pct < 0) ? (cyc % 3 == 0) : ($urandom_range(99) >= bp_pct);
        start_i     = 1'($urandom_range(1));
        mul_ready_i = 1'($urandom_range(1));
        if (m_ready_i) begin
          void'(q.pop_front());
          hs++;
        end
        step();
        start_i     = 1'b0;
        mul_ready_i = 1'b0;
        cyc++;
      end else begin
        done = 1'b1;
      end
    end
    m_ready_i = 1'b0;
    chk({tag, "_drain_in_budget"}, done, 1);
    chk({tag, "_handshakes"}, hs, 16);
    jobs_exp++;
    idle_outputs({tag, "_end"}, jobs_exp);
  endtask

  initial begin
    logic [3:0][3:0][15:0]   mat;
    logic [31:0][31:0][15:0] mat32;
    int n;
    int last_n;

    reset = 1'b1;
    start_i = 1'b0; mul_ready_i = 1'b0; m_ready_i = 1'b0; mul_result_i = '0;
    start32 = 1'b0; mul_ready32 = 1'b0; m_ready32 = 1'b0; mul_result32 = '0;

    // Reset held with random inputs, then mul_ready_i alone in IDLE
    for (int k = 0; k < 2; k++) begin
      start_i = 1'($urandom_range(1));
      mul_ready_i = 1'($urandom_range(1));
      m_ready_i = 1'($urandom_range(1));
      for (int i = 0; i < 4; i++)
        for (int j = 0; j < 4; j++)
          mul_result_i[i][j] = 16'($urandom);
      step();
      idle_outputs("reset", 0);
    end
    reset = 1'b0; start_i = 1'b0; m_ready_i = 1'b1; mul_ready_i = 1'b1;
    step();
    mul_ready_i = 1'b0;
    step();
    idle_outputs("idle_ready", 0);
    m_ready_i = 1'b0;

    // Basic job as a vector table
    load_ramp();
    vecs.push_back('{1, 0, 1, 1, 0, 1, 0, 16'd0, 2'd0, 2'd0, 16'd0});
    vecs.push_back('{0, 0, 1, 1, 0, 1, 0, 16'd0, 2'd0, 2'd0, 16'd0});
    vecs.push_back('{0, 1, 1, 0, 1, 1, 0, 16'd0, 2'd0, 2'd0, 16'd0});
    for (int k = 0; k < 16; k++) begin
      int nx;
      nx = k + 1;
      if (nx < 16)
        vecs.push_back('{0, 0, 1, 0, 1, 1, nx == 15, 16'(16 * (nx / 4) + nx % 4),
                         2'(nx / 4), 2'(nx % 4), 16'd0});
      else
        vecs.push_back('{0, 0, 1, 0, 0, 0, 0, 16'd0, 2'd0, 2'd0, 16'd1});
    end
    foreach (vecs[v]) begin
      start_i = vecs[v].start; mul_ready_i = vecs[v].mul_ready; m_ready_i = vecs[v].m_ready;
      step();
      chk($sformatf("vec%0d_mul_valid", v), mul_valid_o, vecs[v].e_mul_valid);
      chk($sformatf("vec%0d_m_valid", v), m_valid_o, vecs[v].e_m_valid);
      chk($sformatf("vec%0d_busy", v), busy_o, vecs[v].e_busy);
      chk($sformatf("vec%0d_last", v), m_last_o, vecs[v].e_last);
      chk($sformatf("vec%0d_data", v), m_data_o, vecs[v].e_data);
      chk($sformatf("vec%0d_row", v), m_row_o, vecs[v].e_row);
      chk($sformatf("vec%0d_col", v), m_col_o, vecs[v].e_col);
      chk($sformatf("vec%0d_jobs", v), jobs_done_o, vecs[v].e_jobs);
    end
    start_i = 1'b0; mul_ready_i = 1'b0; m_ready_i = 1'b0;
    jobs_exp = 1;

    // Fixed backpressure pattern, capture isolation, then an all-ones job
    load_ramp();
    mat = mul_result_i;
    run_job("bp_pattern", -1, 1'b1, mat);
    run_job("ones", 30, 1'b0, {16{16'hFFFF}});

    // Reset mid-drain with a concurrent handshake
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    load_ramp();
    mul_ready_i = 1'b1;
    step();
    mul_ready_i = 1'b0;
    m_ready_i = 1'b1;
    repeat (5) step();
    chk("mid_data", m_data_o, 17);
    chk("mid_row", m_row_o, 1);
    chk("mid_col", m_col_o, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    m_ready_i = 1'b0;
    jobs_exp = 0;
    idle_outputs("mid_reset", 0);
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        mat[i][j] = 16'($urandom);
    run_job("after_reset", 50, 1'b0, mat);

    // start_i held through a drain: one job, one IDLE cycle, then WAIT
    start_i = 1'b1;
    step();
    chk("hold_req", mul_valid_o, 1);
    load_ramp();
    mul_ready_i = 1'b1;
    step();
    mul_ready_i = 1'b0;
    m_ready_i = 1'b1;
    for (int k = 0; k < 16; k++) begin
      chk("hold_m_valid", m_valid_o, 1);
      chk("hold_data", m_data_o, 16'(16 * (k / 4) + k % 4));
      step();
    end
    jobs_exp++;
    chk("hold_idle_m_valid", m_valid_o, 0);
    chk("hold_idle_mul_valid", mul_valid_o, 0);
    chk("hold_idle_busy", busy_o, 0);
    chk("hold_idle_jobs", jobs_done_o, 32'(jobs_exp));
    step();
    chk("hold_rewait_mul_valid", mul_valid_o, 1);
    chk("hold_rewait_busy", busy_o, 1);
    start_i = 1'b0;
    mul_ready_i = 1'b1;
    step();
    mul_ready_i = 1'b0;
    repeat (16) step();
    m_ready_i = 1'b0;
    jobs_exp++;
    idle_outputs("hold_second", jobs_exp);

    // Randomized jobs against the queue model
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 4; i++)
        for (int j = 0; j < 4; j++)
          mat[i][j] = 16'($urandom);
      run_job($sformatf("rand%0d", r), int'($urandom_range(70)), 1'($urandom_range(1)), mat);
    end

    // SIZE=32 full drain
    start32 = 1'b1;
    step();
    start32 = 1'b0;
    chk("s32_req", mul_valid32, 1);
    for (int i = 0; i < 32; i++)
      for (int j = 0; j < 32; j++)
        mat32[i][j] = 16'($urandom);
    mul_result32 = mat32;
    mul_ready32 = 1'b1;
    step();
    mul_ready32 = 1'b0;
    mul_result32 = '0;
    m_ready32 = 1'b1;
    n = 0;
    last_n = -1;
    while (m_valid32 && n < 1100) begin
      chk("s32_data", m_data32, mat32[n / 32][n % 32]);
      chk("s32_row", m_row32, n / 32);
      chk("s32_col", m_col32, n % 32);
      if (m_last32) last_n = n;
      n++;
      step();
    end
    m_ready32 = 1'b0;
    chk("s32_count", n, 1024);
    chk("s32_last_at", last_n, 1023);
    chk("s32_jobs", jobs32, 1);
    chk("s32_busy", busy32, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
